// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key-schedule block: FSM state enum,
// fixed sizes, the Rcon table and the S-box helpers used by keyScheduleCore.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Round constant for rounds 1..10; round 0 has no constant.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box computed as multiplicative inverse (x^254, so 0 maps to 0)
    // followed by the AES affine transform; avoids a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/keyScheduleCore.sv
// AES key-schedule core: SubWord(RotWord(inputWord)) ^ {Rcon(roundNumber), 24'h0}.
module keyScheduleCore
    import aes_pkg::*;
(
    input  logic [31:0] inputWord,
    input  logic [3:0]  roundNumber,
    output logic [31:0] outputWord
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;

    assign rot_word = {inputWord[23:0], inputWord[31:24]};

    // Byte-wise substitution of the rotated word, then fold in the round constant.
    always_comb begin
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        outputWord = sub_word ^ {rcon(roundNumber), 24'h000000};
    end

endmodule

// File: rtl/inv_key_expansion.sv
// Inverse AES-128 key expansion: given the round-10 key, streams round keys
// 10 down to 0 over a valid/ready handshake, one key per accepted cycle.
// Optional build macro INV_KEY_ZEROIZE_EN clears the key register on the
// final handshake and masks round_key_out whenever key_valid is low.
module inv_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key_out,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done
);

    state_t             state;
    logic [KEY_W-1:0]   key_reg;
    logic [3:0]         round_reg;

    logic [31:0] c0, c1, c2, c3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] core_out;
    logic        handshake;

    // Word 0 lives in the top 32 bits, matching key_in ordering.
    assign c0 = key_reg[127:96];
    assign c1 = key_reg[95:64];
    assign c2 = key_reg[63:32];
    assign c3 = key_reg[31:0];

    // Undo the forward schedule word by word; p0 needs the core term on p3.
    assign p3 = c3 ^ c2;
    assign p2 = c2 ^ c1;
    assign p1 = c1 ^ c0;
    assign p0 = c0 ^ core_out;

    keyScheduleCore u_core (
        .inputWord   (p3),
        .roundNumber (round_reg),
        .outputWord  (core_out)
    );

    assign handshake = key_valid & key_ready;
    assign round_num = round_reg;

`ifdef INV_KEY_ZEROIZE_EN
    assign round_key_out = key_valid ? key_reg : '0;
`else
    assign round_key_out = key_reg;
`endif

    // FSM plus datapath registers; key_valid, busy and done are registered flags.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            round_reg <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg   <= key_in;
                        round_reg <= 4'(NUM_ROUNDS);
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (round_reg != 4'd0) begin
                            key_reg   <= {p0, p1, p2, p3};
                            round_reg <= round_reg - 4'd1;
                        end else begin
`ifdef INV_KEY_ZEROIZE_EN
                            key_reg   <= '0;
`endif
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion using the FIPS-197 AES-128 schedule.
module tb_inv_key_expansion;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key_out;
    logic [3:0]   round_num;
    logic         busy;
    logic         done;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] exp_keys [0:10];
    int           pass_cnt = 0;
    int           chk_cnt  = 0;

    inv_key_expansion dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .key_in        (key_in),
        .key_ready     (key_ready),
        .key_valid     (key_valid),
        .round_key_out (round_key_out),
        .round_num     (round_num),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every accepted key is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_key", {124'd0, round_num}, 128'hffff);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("round_num", {124'd0, round_num}, {124'd0, e.rnd});
                check("round_key", round_key_out, e.key);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), key: exp_keys[r]});
    endtask

    task automatic issue_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        cyc();
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 60) begin
            cyc();
            n++;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(key_valid && round_num == r) && n < 40) begin
            cyc();
            n++;
        end
        if (n >= 40) check("round_timeout", {124'd0, round_num}, {124'd0, r});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst       = 1'b1;
        start     = 1'b0;
        key_ready = 1'b1;
        key_in    = '0;
        cyc();
        cyc();
        check("rst_key_valid", {127'd0, key_valid}, 128'd0);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_done",      {127'd0, done},      128'd0);
        check("rst_round_key", round_key_out,       128'd0);
        check("rst_round_num", {124'd0, round_num}, 128'd0);
        rst = 1'b0;
        cyc();

        // FIPS-197 full sequence, ready held high.
        push_run();
        issue_start(exp_keys[10]);
        check("latency_valid", {127'd0, key_valid}, 128'd1);
        check("latency_busy",  {127'd0, busy},      128'd1);
        check("latency_round", {124'd0, round_num}, 128'd10);
        wait_done(n);
        check("done_cycle", 128'(n + 1), 128'd12);
        check("done_idle_valid", {127'd0, key_valid}, 128'd0);
        cyc();
        check("done_pulse_one", {127'd0, done}, 128'd0);
        check("post_done_busy", {127'd0, busy}, 128'd0);
`ifdef INV_KEY_ZEROIZE_EN
        check("post_done_key", round_key_out, 128'd0);
`else
        check("post_done_key", round_key_out, exp_keys[0]);
`endif

        // Back-pressure at round 7 for 5 cycles.
        push_run();
        issue_start(exp_keys[10]);
        wait_round(4'd7);
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_round", {124'd0, round_num}, 128'd7);
            check("bp_key",   round_key_out,       exp_keys[7]);
        end
        key_ready = 1'b1;
        wait_done(n);
        cyc();

        // Start pulse with a different key while busy at round 4.
        push_run();
        issue_start(exp_keys[10]);
        wait_round(4'd4);
        issue_start(128'h00112233445566778899aabbccddeeff);
        wait_done(n);
        cyc();

        // Reset at round 5 forces outputs to zero immediately.
        push_run();
        issue_start(exp_keys[10]);
        wait_round(4'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {127'd0, key_valid}, 128'd0);
        check("mid_rst_busy",  {127'd0, busy},      128'd0);
        check("mid_rst_key",   round_key_out,       128'd0);
        check("mid_rst_round", {124'd0, round_num}, 128'd0);
        sb_q.delete();
        cyc();
        rst = 1'b0;
        cyc();
        push_run();
        issue_start(exp_keys[10]);
        wait_done(n);

        // Back-to-back: start issued in the done cycle.
        push_run();
        issue_start(exp_keys[10]);
        check("b2b_valid", {127'd0, key_valid}, 128'd1);
        check("b2b_round", {124'd0, round_num}, 128'd10);
        check("b2b_key",   round_key_out,       exp_keys[10]);
        wait_done(n);
        cyc();

        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  load request; sampled only in IDLE.
- key_in  in  128  AES-128 round-10 key; bits [127:96] are word 0, bits [31:0] are word 3.
- key_ready  in  1  consumer accepts round_key_out this cycle.
- key_valid  out  1  round_key_out / round_num hold a valid key.
- round_key_out  out  128  current round key, same word ordering as key_in.
- round_num  out  4  round index of round_key_out, 10 down to 0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after round 0 is accepted.

REQ-002 The block SHALL have no parameters; key width is fixed at 128 bits and the round count at 10.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and EMIT.
REQ-004 In IDLE, start=1 SHALL load key_in into key_reg, set round_reg=10 and move to EMIT on the next edge.
REQ-005 In EMIT, key_valid SHALL be 1, round_key_out SHALL equal key_reg and round_num SHALL equal round_reg.
REQ-006 The handshake is key_valid & key_ready.
- Without a handshake, key_reg and round_reg SHALL hold (back-pressure with no limit).
REQ-007 On a handshake with round_reg>0, the block SHALL load key_reg with the previous round key and decrement round_reg.
- This gives a throughput of one key per cycle when key_ready is held high.
REQ-008 The previous round key SHALL be computed from current words c0..c3 as follows:
- p3=c3^c2
- p2=c2^c1
- p1=c1^c0
- p0=c0^SubWord(RotWord(p3))^Rcon(round_reg)
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36 in the top byte.
REQ-009 On a handshake with round_reg==0, the block SHALL return to IDLE and assert done for exactly the next cycle.
REQ-010 start asserted in EMIT SHALL be ignored and SHALL NOT restart or corrupt the sequence.
REQ-011 start asserted in the same cycle that done is high (IDLE) SHALL be accepted normally.
REQ-012 Latency from start to the first key_valid SHALL be 1 cycle.
REQ-013 A full 11-key sequence SHALL take 12 cycles from start to done when key_ready is held at 1.
REQ-014 All datapath XORs SHALL be 32-bit.
- round_reg SHALL never wrap below 0.

Reset
REQ-015 Asserting rst at any time SHALL immediately force the following, aborting any sequence in progress:
- state=IDLE
- key_reg=0, round_reg=0
- key_valid=0, busy=0, done=0
- round_key_out=0, round_num=0
REQ-016 After rst deasserts, the first start SHALL behave per REQ-004.

Configuration
REQ-017 Macro INV_KEY_ZEROIZE_EN SHALL control key zeroization as follows:
- Defined: on the round-0 handshake, key_reg SHALL be cleared to 0, and round_key_out SHALL read 0 whenever key_valid=0.
- Undefined: key_reg SHALL retain the round-0 key after completion, and round_key_out SHALL always reflect key_reg.

Structure
REQ-018 A shared package aes_pkg SHALL hold:
- the state enum (IDLE, EMIT)
- the constants NUM_ROUNDS=10 and KEY_W=128
- the Rcon lookup function
REQ-019 The block SHALL instantiate the existing keyScheduleCore exactly once, with these connections:
- inputWord=p3
- roundNumber=round_reg
- outputWord=SubWord(RotWord)^Rcon term
REQ-020 No further sub-modules SHALL be used.

Verification
REQ-021 FIPS-197 vector: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and key_ready=1.
- Required: round 10 key as given, then round 9 = ac7766f319fadc2128d12941575c006e.
- Required: round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with done at cycle 12.
REQ-022 Back-pressure: hold key_ready=0 for 5 cycles at round 7.
- Required: round_key_out and round_num=7 stable throughout; the sequence resumes correctly afterwards.
REQ-023 Start while busy: pulse start with a different key_in at round 4.
- Required: the sequence is unaffected and still ends with 2b7e1516... at round 0.
REQ-024 Reset mid-sequence: assert rst at round 5.
- Required: all outputs 0 in the same cycle.
- Required: a new start after reset produces a correct full sequence.
REQ-025 Back-to-back runs: assert start in the done cycle.
- Required: the new sequence begins with round 10 one cycle later.
REQ-026 Zeroization with INV_KEY_ZEROIZE_EN defined: after done, round_key_out=0.
- Without the macro: round_key_out=2b7e151628aed2a6abf7158809cf4f3c with key_valid=0.
